// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between NREQ requesters.
// Capture in IDLE, compute in EXEC, hold the tagged result in DONE until accepted.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      result,
  output logic [IDW-1:0]        result_id,
  output logic                  result_valid,
  input  logic                  result_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   ptr, win_id, winner, idx;
  logic             found;
  logic             capture, compute, handshake;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, f;

  logic [2:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi] = op[3*gi +: 3];
    assign a_arr[gi]  = a[WIDTH*gi +: WIDTH];
    assign b_arr[gi]  = b[WIDTH*gi +: WIDTH];
  end

  // Scan offsets from high to low so the smallest offset from ptr wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDW'(k);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (result_valid && result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture   = (state == IDLE) && found;
    compute   = (state == EXEC);
    handshake = (state == DONE) && result_valid && result_ready;
    busy      = (state != IDLE);
  end

  always_comb begin
    f = '0;
    case (op_r)
      3'b000: f = ~a_r;
      3'b001: f = a_r & b_r;
      3'b010: f = a_r | b_r;
      3'b011: f = a_r ^ b_r;
      3'b100: f = ~(a_r ^ b_r);
      3'b101: f = ~(a_r & b_r);
      3'b110: f = ~(a_r | b_r);
      default: f = a_r;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt          <= '0;
      win_id       <= '0;
      ptr          <= '0;
      op_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      result       <= '0;
      result_id    <= '0;
      result_valid <= 1'b0;
    end else begin
      gnt <= '0;
      if (capture) begin
        op_r   <= op_arr[winner];
        a_r    <= a_arr[winner];
        b_r    <= b_arr[winner];
        win_id <= winner;
        gnt    <= NREQ'(1) << winner;
      end
      if (compute) begin
        result       <= f;
        result_id    <= win_id;
        result_valid <= 1'b1;
      end
      // Pointer moves only once the result is accepted, to the slot after the winner.
      if (handshake) begin
        result_valid <= 1'b0;
        ptr          <= win_id + IDW'(1);
      end
    end
  end

endmodule
